// File: rtl/sort_bank_pkg.sv
// Shared constants and state encoding for the sort_bank key sorter.
package sort_bank_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned NSLOT   = 8;
    localparam int unsigned PHASES  = 8;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned PHASE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_swap.sv
// Compare-exchange element: lo goes to the lower slot, hi to the upper slot.
module cmp_swap #(
    parameter int unsigned WIDTH   = 4,
    parameter bit          DESCEND = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap_c;

    // Strict compare so equal keys never move.
    always_comb begin
        swap_c = DESCEND ? (a < b) : (a > b);
        lo     = swap_c ? b : a;
        hi     = swap_c ? a : b;
    end

endmodule

// File: rtl/sort_bank.sv
// Eight-slot key bank sorted in place by an 8-phase odd-even transposition network.
module sort_bank
    import sort_bank_pkg::*;
#(
    parameter int unsigned WIDTH   = KEY_W,
    parameter bit          DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sorted,
    output logic [WIDTH-1:0]  zero,
    output logic [WIDTH-1:0]  one,
    output logic [WIDTH-1:0]  two,
    output logic [WIDTH-1:0]  three,
    output logic [WIDTH-1:0]  four,
    output logic [WIDTH-1:0]  five,
    output logic [WIDTH-1:0]  six,
    output logic [WIDTH-1:0]  seven
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [WIDTH-1:0]     slot     [NSLOT];
    logic [WIDTH-1:0]     even_nxt [NSLOT];
    logic [WIDTH-1:0]     odd_nxt  [NSLOT];

    // Even phase: pairs (0,1) (2,3) (4,5) (6,7).
    for (genvar k = 0; k < NSLOT / 2; k++) begin : g_even
        cmp_swap #(.WIDTH(WIDTH), .DESCEND(DESCEND)) u_cs (
            .a  (slot[2*k]),
            .b  (slot[2*k+1]),
            .lo (even_nxt[2*k]),
            .hi (even_nxt[2*k+1])
        );
    end

    // Odd phase: pairs (1,2) (3,4) (5,6); end slots hold.
    for (genvar k = 0; k < NSLOT / 2 - 1; k++) begin : g_odd
        cmp_swap #(.WIDTH(WIDTH), .DESCEND(DESCEND)) u_cs (
            .a  (slot[2*k+1]),
            .b  (slot[2*k+2]),
            .lo (odd_nxt[2*k+1]),
            .hi (odd_nxt[2*k+2])
        );
    end

    assign odd_nxt[0]       = slot[0];
    assign odd_nxt[NSLOT-1] = slot[NSLOT-1];

    // FSM, phase counter, slot registers and write decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSLOT; i++) begin
                slot[i] <= '0;
            end
            state  <= IDLE;
            phase  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sorted <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        slot[wr_addr] <= wr_data;
                        sorted        <= 1'b0;
                    end
                    if (start) begin
                        state <= SORT;
                        phase <= '0;
                        busy  <= 1'b1;
                    end
                end
                SORT: begin
                    for (int i = 0; i < NSLOT; i++) begin
                        slot[i] <= phase[0] ? odd_nxt[i] : even_nxt[i];
                    end
                    phase <= phase + PHASE_W'(1);
                    if (phase == LAST_PHASE) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        sorted <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign zero  = slot[0];
    assign one   = slot[1];
    assign two   = slot[2];
    assign three = slot[3];
    assign four  = slot[4];
    assign five  = slot[5];
    assign six   = slot[6];
    assign seven = slot[7];

endmodule

// File: tb/tb_sort_bank.sv
// Self-checking bench for sort_bank: ascending and descending instances share stimulus.
module tb_sort_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       start = 1'b0;

    logic       busy_a, done_a, sorted_a;
    logic       busy_d, done_d, sorted_d;
    logic [3:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [3:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [31:0] out_a, out_d;

    int total = 0;
    int bad   = 0;

    logic [31:0] ma = '0;
    logic [31:0] md = '0;

    always #5 clk = ~clk;

    sort_bank #(.WIDTH(4), .DESCEND(1'b0)) u_asc (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy_a), .done(done_a), .sorted(sorted_a),
        .zero(a0), .one(a1), .two(a2), .three(a3),
        .four(a4), .five(a5), .six(a6), .seven(a7)
    );

    sort_bank #(.WIDTH(4), .DESCEND(1'b1)) u_desc (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy_d), .done(done_d), .sorted(sorted_d),
        .zero(d0), .one(d1), .two(d2), .three(d3),
        .four(d4), .five(d5), .six(d6), .seven(d7)
    );

    assign out_a = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign out_d = {d7, d6, d5, d4, d3, d2, d1, d0};

    typedef struct {
        logic [31:0] keys;
        logic [31:0] exp_asc;
        logic [31:0] exp_desc;
    } vec_t;

    // Reference: counting sort over the 16 key values; slot i lives at bits [4i+3:4i].
    function automatic logic [31:0] ref_sort(logic [31:0] v, bit desc);
        int          cnt [16];
        int          k;
        int          val;
        logic [31:0] r;
        r = '0;
        k = 0;
        for (int n = 0; n < 16; n++) cnt[n] = 0;
        for (int i = 0; i < 8; i++) cnt[v[4*i +: 4]]++;
        for (int n = 0; n < 16; n++) begin
            val = desc ? 15 - n : n;
            for (int c = 0; c < cnt[val]; c++) begin
                r[4*k +: 4] = 4'(val);
                k++;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_key(logic [2:0] addr, logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en = 1'b0;
        ma[4*addr +: 4] = data;
        md[4*addr +: 4] = data;
    endtask

    task automatic load_all(logic [31:0] keys);
        for (int i = 0; i < 8; i++) write_key(3'(i), keys[4*i +: 4]);
    endtask

    // Pulse start, measure the busy window and check the done pulse and result.
    task automatic run_sort(string tag);
        int c;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (busy_a && c < 20) begin
            c++;
            tick();
        end
        ma = ref_sort(ma, 1'b0);
        md = ref_sort(md, 1'b1);
        chk({tag, " busy cycles"}, 32'(c), 32'd8);
        chk({tag, " done pulse"}, {30'd0, done_a, done_d}, 32'd3);
        tick();
        chk({tag, " done cleared"}, {30'd0, done_a, done_d}, 32'd0);
        chk({tag, " sorted"}, {30'd0, sorted_a, sorted_d}, 32'd3);
        chk({tag, " asc out"}, out_a, ma);
        chk({tag, " desc out"}, out_d, md);
    endtask

    initial begin
        vec_t vecs [4];
        int   dones;
        vecs[0] = '{32'h81390F37, 32'hF9873310, 32'h0133789F};
        vecs[1] = '{32'h01234567, 32'h76543210, 32'h01234567};
        vecs[2] = '{32'h55555555, 32'h55555555, 32'h55555555};
        vecs[3] = '{32'h0F0F0F0F, 32'hFFFF0000, 32'h0000FFFF};

        // Reset held for two cycles.
        rst = 1'b1;
        tick();
        tick();
        chk("reset asc out", out_a, 32'd0);
        chk("reset desc out", out_d, 32'd0);
        chk("reset flags", {26'd0, busy_a, done_a, sorted_a, busy_d, done_d, sorted_d}, 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven vectors with hand-computed expectations.
        for (int v = 0; v < 4; v++) begin
            load_all(vecs[v].keys);
            chk($sformatf("vec%0d sorted cleared", v), {31'd0, sorted_a}, 32'd0);
            run_sort($sformatf("vec%0d", v));
            chk($sformatf("vec%0d asc table", v), out_a, vecs[v].exp_asc);
            chk($sformatf("vec%0d desc table", v), out_d, vecs[v].exp_desc);
        end

        // Start while already sorted: full sort, contents unchanged.
        run_sort("resort");
        chk("resort asc table", out_a, 32'h0FFFF0000 & 32'hFFFF0000);

        // wr_en and start during SORT are ignored.
        load_all(vecs[0].keys);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 4'hA;
        start   = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_a) dones++;
            tick();
        end
        ma = ref_sort(ma, 1'b0);
        md = ref_sort(md, 1'b1);
        chk("ignore done count", 32'(dones), 32'd1);
        chk("ignore asc out", out_a, vecs[0].exp_asc);
        chk("ignore desc out", out_d, vecs[0].exp_desc);
        chk("ignore busy idle", {31'd0, busy_a}, 32'd0);

        // Write and start on the same edge: write lands before the first compare.
        load_all(32'h76543210);
        wr_en   = 1'b1;
        wr_addr = 3'd0;
        wr_data = 4'h5;
        ma[3:0] = 4'h5;
        md[3:0] = 4'h5;
        run_sort("same edge");
        chk("same edge asc table", out_a, 32'h76554321);

        // Reset at SORT phase 4 abandons the sort with no done.
        load_all(vecs[0].keys);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ma = '0;
        md = '0;
        chk("midsort rst asc", out_a, 32'd0);
        chk("midsort rst desc", out_d, 32'd0);
        chk("midsort rst flags", {26'd0, busy_a, done_a, sorted_a, busy_d, done_d, sorted_d}, 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_a || done_d || busy_a) dones++;
            tick();
        end
        chk("midsort no done", 32'(dones), 32'd0);
        load_all(vecs[0].keys);
        run_sort("after rst");

        // Randomized partial writes against the reference model.
        for (int r = 0; r < 20; r++) begin
            int nw;
            nw = 0;
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    write_key(3'(i), 4'($urandom_range(0, 15)));
                    nw++;
                end
            end
            if (nw > 0) chk($sformatf("rnd%0d sorted cleared", r), {31'd0, sorted_a}, 32'd0);
            run_sort($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
